// File: rtl/mpu_prog_seq_pkg.sv
// rtl/mpu_prog_seq_pkg.sv - shared MPU region types and sequencer state encoding
package mpu_prog_seq_pkg;

  localparam int SMPUCTL_LOCK_BIT = 0;

  typedef enum logic [1:0] {ACC_R = 2'd0, ACC_W = 2'd1, ACC_X = 2'd2} acc_e;
  typedef enum logic [1:0] {PRIV_U = 2'd0, PRIV_S = 2'd1, PRIV_M = 2'd3} priv_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] base;
    logic [31:0] limit;
    logic        allow_x;
    logic        allow_w;
    logic        allow_r;
    logic        user_ok;
    logic        is_ispace;
  } mpu_region_s;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE} seq_state_e;

  // xwr is {X,W,R}; every descriptor written to the MPU is marked valid.
  function automatic mpu_region_s make_region(input logic [31:0] base,
                                              input logic [31:0] limit,
                                              input logic [2:0]  xwr,
                                              input logic        user_ok,
                                              input logic        is_ispace);
    mpu_region_s r;
    r.valid     = 1'b1;
    r.base      = base;
    r.limit     = limit;
    r.allow_x   = xwr[2];
    r.allow_w   = xwr[1];
    r.allow_r   = xwr[0];
    r.user_ok   = user_ok;
    r.is_ispace = is_ispace;
    return r;
  endfunction

endpackage

// File: rtl/mpu_prog_seq_if.sv
// rtl/mpu_prog_seq_if.sv - request channel from the CSR/boot path into the sequencer
interface mpu_prog_seq_if #(parameter int IDXW = 3);
  logic            req_valid;
  logic            req_ready;
  logic            req_lock;
  logic [IDXW-1:0] req_idx;
  logic [31:0]     req_base;
  logic [31:0]     req_limit;
  logic [2:0]      req_xwr;
  logic            req_user_ok;
  logic            req_is_ispace;

  modport master (
    output req_valid, req_lock, req_idx, req_base, req_limit, req_xwr,
           req_user_ok, req_is_ispace,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_lock, req_idx, req_base, req_limit, req_xwr,
           req_user_ok, req_is_ispace,
    output req_ready
  );
endinterface

// File: rtl/mpu_prog_seq_fifo.sv
// rtl/mpu_prog_seq_fifo.sv - synchronous request FIFO, head visible combinationally
module mpu_prog_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // full comes from the registered count, so a same-cycle pop never frees a slot
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mpu_prog_seq.sv
// rtl/mpu_prog_seq.sv - replays queued region descriptors and lock requests onto the MPU prog port
module mpu_prog_seq
  import mpu_prog_seq_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int DEPTH = 4,
  parameter int IDXW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  mpu_prog_seq_if.slave        csr,
  output logic                 prog_en,
  output logic [IDXW-1:0]      prog_idx,
  output mpu_region_s          prog_region,
  output logic                 lock_o,
  output logic                 err_locked,
  output logic                 err_range,
  output logic                 busy
);

  if ((1 << IDXW) != NREG) begin : g_nreg_chk
    $error("mpu_prog_seq: NREG must be a power of two equal to 2**IDXW");
  end
  if (DEPTH < 2 || (1 << $clog2(DEPTH)) != DEPTH) begin : g_depth_chk
    $error("mpu_prog_seq: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic            lock;
    logic [IDXW-1:0] idx;
    logic [31:0]     base;
    logic [31:0]     limit;
    logic [2:0]      xwr;
    logic            user_ok;
    logic            is_ispace;
  } entry_t;

  entry_t      in_entry;
  entry_t      head;
  logic        full;
  logic        empty;
  logic        pop;

  seq_state_e      state_q, state_d;
  logic            prog_en_d;
  logic [IDXW-1:0] prog_idx_d;
  mpu_region_s     region_d;
  logic            lock_d;
  logic            err_locked_d;
  logic            err_range_d;

  assign in_entry = {csr.req_lock, csr.req_idx, csr.req_base, csr.req_limit,
                     csr.req_xwr, csr.req_user_ok, csr.req_is_ispace};
  assign csr.req_ready = !full;

  mpu_prog_seq_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (csr.req_valid),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    prog_en_d    = 1'b0;
    prog_idx_d   = prog_idx;
    region_d     = prog_region;
    lock_d       = lock_o;
    err_locked_d = 1'b0;
    err_range_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.lock) begin
            lock_d  = 1'b1;
            state_d = ST_SETTLE;
          end else if (lock_o) begin
            err_locked_d = 1'b1;
          end else if (head.limit < head.base) begin
            err_range_d = 1'b1;
          end else begin
            prog_en_d  = 1'b1;
            prog_idx_d = head.idx;
            region_d   = make_region(head.base, head.limit, head.xwr,
                                     head.user_ok, head.is_ispace);
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      // SETTLE gives the MPU a cycle to make the update visible before the next write
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prog_en     <= 1'b0;
      prog_idx    <= '0;
      prog_region <= '0;
      lock_o      <= 1'b0;
      err_locked  <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_en     <= prog_en_d;
      prog_idx    <= prog_idx_d;
      prog_region <= region_d;
      lock_o      <= lock_d;
      err_locked  <= err_locked_d;
      err_range   <= err_range_d;
    end
  end

  assign busy = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mpu_prog_seq.sv
// tb/tb_mpu_prog_seq.sv - directed self-checking bench for mpu_prog_seq
module tb_mpu_prog_seq;
  import mpu_prog_seq_pkg::*;

  localparam int NREG  = 8;
  localparam int DEPTH = 4;
  localparam int IDXW  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            prog_en;
  logic [IDXW-1:0] prog_idx;
  mpu_region_s     prog_region;
  logic            lock_o;
  logic            err_locked;
  logic            err_range;
  logic            busy;

  mpu_prog_seq_if #(.IDXW(IDXW)) rif();

  mpu_prog_seq #(.NREG(NREG), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr         (rif),
    .prog_en     (prog_en),
    .prog_idx    (prog_idx),
    .prog_region (prog_region),
    .lock_o      (lock_o),
    .err_locked  (err_locked),
    .err_range   (err_range),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lock_cyc = -1;
  int coinc = 0;
  int pe_cyc[$];
  logic [IDXW-1:0] pe_idx[$];
  mpu_region_s pe_reg[$];
  int el_cyc[$];
  int er_cyc[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (prog_en) begin
      pe_cyc.push_back(cyc);
      pe_idx.push_back(prog_idx);
      pe_reg.push_back(prog_region);
    end
    if (err_locked) el_cyc.push_back(cyc);
    if (err_range) er_cyc.push_back(cyc);
    if (lock_o && lock_cyc < 0) lock_cyc = cyc;
    if ((err_locked || err_range) && prog_en) coinc++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    pe_cyc.delete();
    pe_idx.delete();
    pe_reg.delete();
    el_cyc.delete();
    er_cyc.delete();
    lock_cyc = -1;
  endtask

  task automatic send(input logic lk, input logic [IDXW-1:0] idx,
                      input logic [31:0] b, input logic [31:0] l,
                      input logic [2:0] xwr, input logic uo, input logic is,
                      output int hs);
    int n = 0;
    rif.req_valid     = 1'b1;
    rif.req_lock      = lk;
    rif.req_idx       = idx;
    rif.req_base      = b;
    rif.req_limit     = l;
    rif.req_xwr       = xwr;
    rif.req_user_ok   = uo;
    rif.req_is_ispace = is;
    while (!rif.req_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) check_eq("send_timeout", rif.req_ready, 1);
    @(posedge clk); #2;
    hs = cyc;
    rif.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) check_eq("idle_timeout", busy, 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  initial begin
    int hs[6];
    int h;
    rst = 1'b1;
    rif.req_valid = 1'b0; rif.req_lock = 1'b0; rif.req_idx = '0;
    rif.req_base = '0; rif.req_limit = '0; rif.req_xwr = '0;
    rif.req_user_ok = 1'b0; rif.req_is_ispace = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_prog_en", prog_en, 0);
    check_eq("rst_ready", rif.req_ready, 1);
    check_eq("rst_lock", lock_o, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_errs", {err_locked, err_range}, 0);
    check_eq("rst_region", prog_region, 0);
    rst = 1'b0;
    clear_log();

    // single write
    send(1'b0, 3'd1, 32'h2000_0000, 32'h2001_FFFF, 3'b011, 1'b1, 1'b0, h);
    wait_idle();
    check_eq("s_count", pe_cyc.size(), 1);
    check_eq("s_lat", qget(pe_cyc, 0), h + 1);
    if (pe_reg.size() > 0) begin
      check_eq("s_idx", pe_idx[0], 1);
      check_eq("s_valid", pe_reg[0].valid, 1);
      check_eq("s_base", pe_reg[0].base, 32'h2000_0000);
      check_eq("s_limit", pe_reg[0].limit, 32'h2001_FFFF);
      check_eq("s_xwr", {pe_reg[0].allow_x, pe_reg[0].allow_w, pe_reg[0].allow_r}, 3'b011);
      check_eq("s_uo_is", {pe_reg[0].user_ok, pe_reg[0].is_ispace}, 2'b10);
    end
    check_eq("s_hold_idx", prog_idx, 1);
    check_eq("s_hold_base", prog_region.base, 32'h2000_0000);
    clear_log();

    // burst of 6: FIFO fills after the 6th handshake, pulses every 3 cycles
    for (int k = 0; k < 6; k++)
      send(1'b0, IDXW'(k), 32'h1000 * k, 32'h1000 * k + 32'hFFF, 3'b001, 1'b0, 1'b0, hs[k]);
    check_eq("b_full", rif.req_ready, 0);
    check_eq("b_contig", hs[5] - hs[0], 5);
    wait_idle();
    check_eq("b_count", pe_cyc.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("b_cyc%0d", k), qget(pe_cyc, k), hs[0] + 1 + 3 * k);
      if (k < pe_idx.size()) check_eq($sformatf("b_idx%0d", k), pe_idx[k], k);
    end
    check_eq("b_ready", rif.req_ready, 1);
    clear_log();

    // range error then base==limit
    send(1'b0, 3'd2, 32'h1000_1000, 32'h1000_0FFF, 3'b001, 1'b0, 1'b0, h);
    wait_idle();
    check_eq("r_err", er_cyc.size(), 1);
    check_eq("r_err_cyc", qget(er_cyc, 0), h + 1);
    check_eq("r_no_pe", pe_cyc.size(), 0);
    send(1'b0, 3'd2, 32'h1000_0000, 32'h1000_0000, 3'b001, 1'b0, 1'b0, h);
    wait_idle();
    check_eq("r_eq_pe", pe_cyc.size(), 1);
    if (pe_reg.size() > 0) check_eq("r_eq_lim", pe_reg[0].limit, 32'h1000_0000);
    check_eq("r_err_once", er_cyc.size(), 1);
    clear_log();

    // reset on the edge where the second write would issue, 3 entries queued
    for (int k = 0; k < 4; k++)
      send(1'b0, IDXW'(k + 4), 32'h4000_0000, 32'h4000_FFFF, 3'b001, 1'b0, 1'b0, hs[k]);
    rst = 1'b1;
    @(posedge clk); #2;
    check_eq("m_prog_en", prog_en, 0);
    check_eq("m_busy", busy, 0);
    check_eq("m_lock", lock_o, 0);
    check_eq("m_ready", rif.req_ready, 1);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check_eq("m_count", pe_cyc.size(), 1);
    check_eq("m_first", qget(pe_cyc, 0), hs[0] + 1);
    clear_log();

    // lock ordering: write, lock, write
    send(1'b0, 3'd0, 32'h0800_0000, 32'h0800_FFFF, 3'b101, 1'b0, 1'b1, hs[0]);
    send(1'b1, 3'd0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, hs[1]);
    send(1'b0, 3'd1, 32'h0900_0000, 32'h0900_FFFF, 3'b111, 1'b1, 1'b0, hs[2]);
    wait_idle();
    check_eq("l_pe_count", pe_cyc.size(), 1);
    if (pe_reg.size() > 0) begin
      check_eq("l_idx", pe_idx[0], 0);
      check_eq("l_x", pe_reg[0].allow_x, 1);
    end
    check_eq("l_lock_cyc", lock_cyc, hs[0] + 4);
    check_eq("l_el_count", el_cyc.size(), 1);
    check_eq("l_el_cyc", qget(el_cyc, 0), hs[0] + 6);
    check_eq("l_er_none", er_cyc.size(), 0);
    check_eq("l_lock", lock_o, 1);
    check_eq("l_ready", rif.req_ready, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    check_eq("l_rst_lock", lock_o, 0);
    rst = 1'b0;
    clear_log();

    // double lock
    send(1'b1, 3'd0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, hs[0]);
    send(1'b1, 3'd0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, hs[1]);
    repeat (6) @(posedge clk);
    #2;
    check_eq("d_busy", busy, 0);
    check_eq("d_lock", lock_o, 1);
    check_eq("d_lock_cyc", lock_cyc, hs[0] + 1);
    check_eq("d_errs", el_cyc.size() + er_cyc.size(), 0);
    check_eq("d_no_pe", pe_cyc.size(), 0);

    check_eq("no_coincide", coinc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
